// File: rtl/ldm_pkg.sv
// ldm_pkg: constants and helpers shared by the LDM line packer and unpacker.
// Keeping the line-to-bit mapping in one place guarantees that a frame packed
// here comes back out of the unpacker with line k at address k.
package ldm_pkg;

  localparam int LDM_LINE_W    = 16;
  localparam int LDM_NUM_LINES = 16;
  localparam int LDM_ADDR_W    = 4;
  localparam int LDM_FRAME_W   = LDM_LINE_W * LDM_NUM_LINES;
  localparam int LDM_BIT_W     = $clog2(LDM_FRAME_W);

  // Frame-output state of the packer; the held frame is what valid reports.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } packer_state_t;

  // Line slot k starts at bit LDM_LINE_W*k; line 0 is least significant.
  function automatic logic [LDM_BIT_W-1:0] ldm_slot_base(input logic [LDM_ADDR_W-1:0] k);
    return LDM_BIT_W'(k) * LDM_BIT_W'(LDM_LINE_W);
  endfunction

endpackage

// File: rtl/s2p_line_packer.sv
// s2p_line_packer: collects NUM_LINES line words from the LDM line stream and
// presents them as one packed pixel frame. The assembly buffer and the output
// register form a double buffer, so the next frame is collected while the
// previous one waits for the consumer.
//
// Ports
//   clk, rstn          system clock, asynchronous active-low reset
//   LDM_FRAME_START    resync strobe: current/next accepted line becomes line 0
//   LDM_LINE_DATA      line word, taken when LDM_LINE_VALID && LDM_LINE_READY
//   LDM_LINE_VALID     line word valid
//   LDM_LINE_READY     packer can take a line this cycle
//   LDM_ADDR           slot the next accepted line is written to
//   PIXEL_DATA_256     assembled frame (line k at [LINE_W*k +: LINE_W])
//   PIXEL_DATA_VALID   output register holds an unconsumed frame
//   PIXEL_DATA_READY   downstream takes the frame
//   FRAME_DROP         one-cycle pulse when a resync discards a partial frame
//
// state    | meaning
// ST_EMPTY | no frame held; every line is accepted
// ST_HOLD  | frame held; only the final line stalls until it is consumed
module s2p_line_packer
  import ldm_pkg::*;
#(
  parameter  int LINE_W    = LDM_LINE_W,
  parameter  int NUM_LINES = LDM_NUM_LINES,
  localparam int DATA_W    = LINE_W * NUM_LINES,
  localparam int ADDR_W    = $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              LDM_FRAME_START,
  input  logic [LINE_W-1:0] LDM_LINE_DATA,
  input  logic              LDM_LINE_VALID,
  output logic              LDM_LINE_READY,
  output logic [ADDR_W-1:0] LDM_ADDR,
  output logic [DATA_W-1:0] PIXEL_DATA_256,
  output logic              PIXEL_DATA_VALID,
  input  logic              PIXEL_DATA_READY,
  output logic              FRAME_DROP
);

  packer_state_t     r_state;
  packer_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] r_buf;
  logic [DATA_W-1:0] r_frame;
  logic [DATA_W-1:0] w_merged;
  logic              r_drop;
  logic              w_valid;
  logic              w_line_ready;
  logic              w_last;
  logic              w_accept;
  logic              w_complete;

  assign w_last     = (r_cnt == ADDR_W'(NUM_LINES - 1));
  assign w_accept   = LDM_LINE_VALID && w_line_ready;
  // A resync turns an accepted last-slot line into line 0, so it cannot complete.
  assign w_complete = w_accept && w_last && !LDM_FRAME_START;
  assign w_wr_addr  = LDM_FRAME_START ? '0 : r_cnt;

  // Buffer with the incoming word dropped into its slot; feeds both the
  // assembly buffer and, on the final line, the output register.
  always_comb begin
    w_merged = r_buf;
    w_merged[ldm_slot_base(w_wr_addr) +: LINE_W] = LDM_LINE_DATA;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (LDM_FRAME_START) begin
      w_cnt_nxt = w_accept ? ADDR_W'(1) : '0;
    end else if (w_accept) begin
      w_cnt_nxt = r_cnt + ADDR_W'(1);
    end
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_complete) w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_complete)            w_state_nxt = ST_HOLD;
        else if (PIXEL_DATA_READY) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // outputs; ready looks at same-cycle PIXEL_DATA_READY so a drain and the
  // final line can share one edge without a bubble
  always_comb begin
    w_valid      = (r_state == ST_HOLD);
    w_line_ready = !(w_last && w_valid && !PIXEL_DATA_READY);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_buf   <= '0;
      r_frame <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_drop <= LDM_FRAME_START && (r_cnt != '0);
      if (w_accept) begin
        r_buf <= w_merged;
      end
      if (w_complete) begin
        r_frame <= w_merged;
      end
    end
  end

  assign LDM_LINE_READY   = w_line_ready;
  assign LDM_ADDR         = r_cnt;
  assign PIXEL_DATA_256   = r_frame;
  assign PIXEL_DATA_VALID = w_valid;
  assign FRAME_DROP       = r_drop;

endmodule

// File: tb/tb_s2p_line_packer.sv
// tb_s2p_line_packer: directed and randomised-handshake checks of the packer.
module tb_s2p_line_packer;

  logic         clk;
  logic         rstn;
  logic         LDM_FRAME_START;
  logic [15:0]  LDM_LINE_DATA;
  logic         LDM_LINE_VALID;
  logic         LDM_LINE_READY;
  logic [3:0]   LDM_ADDR;
  logic [255:0] PIXEL_DATA_256;
  logic         PIXEL_DATA_VALID;
  logic         PIXEL_DATA_READY;
  logic         FRAME_DROP;

  int n_vec;
  int n_err;

  s2p_line_packer dut (
    .clk              (clk),
    .rstn             (rstn),
    .LDM_FRAME_START  (LDM_FRAME_START),
    .LDM_LINE_DATA    (LDM_LINE_DATA),
    .LDM_LINE_VALID   (LDM_LINE_VALID),
    .LDM_LINE_READY   (LDM_LINE_READY),
    .LDM_ADDR         (LDM_ADDR),
    .PIXEL_DATA_256   (PIXEL_DATA_256),
    .PIXEL_DATA_VALID (PIXEL_DATA_VALID),
    .PIXEL_DATA_READY (PIXEL_DATA_READY),
    .FRAME_DROP       (FRAME_DROP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input logic [15:0] d);
    LDM_LINE_VALID = 1'b1;
    LDM_LINE_DATA  = d;
    tick();
  endtask

  // line k = base + k
  function automatic logic [255:0] mk_frame(input logic [15:0] base);
    logic [255:0] f;
    for (int k = 0; k < 16; k++) f[16*k +: 16] = base + 16'(k);
    return f;
  endfunction

  // line k = {frame number, k}
  function automatic logic [255:0] pat_frame(input int fn);
    logic [255:0] f;
    for (int k = 0; k < 16; k++) f[16*k +: 16] = {12'(fn), 4'(k)};
    return f;
  endfunction

  initial begin
    logic [255:0] exp_f;
    logic [15:0]  d;
    int tx, rx, cyc;
    logic acc;

    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    LDM_FRAME_START  = 1'b0;
    LDM_LINE_DATA    = 16'h0;
    LDM_LINE_VALID   = 1'b0;
    PIXEL_DATA_READY = 1'b0;
    tick();
    tick();
    chk("rst_valid", PIXEL_DATA_VALID, 0);
    chk("rst_data",  PIXEL_DATA_256, 0);
    chk("rst_ready", LDM_LINE_READY, 1);
    chk("rst_addr",  LDM_ADDR, 0);
    chk("rst_drop",  FRAME_DROP, 0);
    rstn = 1'b1;
    tick();

    // back-to-back frame, consumer always ready
    PIXEL_DATA_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t1_valid_before_last", PIXEL_DATA_VALID, 0);
      send_line(16'(i));
    end
    LDM_LINE_VALID = 1'b0;
    chk("t1_valid", PIXEL_DATA_VALID, 1);
    chk("t1_frame", PIXEL_DATA_256, mk_frame(16'h0000));
    chk("t1_line0", PIXEL_DATA_256[15:0], 16'h0000);
    chk("t1_line15", PIXEL_DATA_256[255:240], 16'h000F);
    tick();
    chk("t1_valid_drop", PIXEL_DATA_VALID, 0);

    // backpressure on the final line only
    PIXEL_DATA_READY = 1'b0;
    for (int i = 0; i < 16; i++) send_line(16'hA000 + 16'(i));
    LDM_LINE_VALID = 1'b0;
    chk("t2_a_valid", PIXEL_DATA_VALID, 1);
    chk("t2_a_frame", PIXEL_DATA_256, mk_frame(16'hA000));
    for (int i = 0; i < 15; i++) send_line(16'hB000 + 16'(i));
    LDM_LINE_VALID = 1'b1;
    LDM_LINE_DATA  = 16'hB00F;
    #1;
    chk("t2_stall_addr", LDM_ADDR, 15);
    chk("t2_stall_ready", LDM_LINE_READY, 0);
    tick();
    chk("t2_stall_hold_addr", LDM_ADDR, 15);
    chk("t2_a_stable", PIXEL_DATA_256, mk_frame(16'hA000));
    PIXEL_DATA_READY = 1'b1;
    #1;
    chk("t2_ready_release", LDM_LINE_READY, 1);
    tick();
    LDM_LINE_VALID = 1'b0;
    chk("t2_b_valid", PIXEL_DATA_VALID, 1);
    chk("t2_b_frame", PIXEL_DATA_256, mk_frame(16'hB000));
    chk("t2_addr_wrap", LDM_ADDR, 0);
    tick();
    chk("t2_b_consumed", PIXEL_DATA_VALID, 0);

    // resync with a line on the same edge
    for (int i = 0; i < 5; i++) send_line(16'hC000 + 16'(i));
    LDM_LINE_VALID = 1'b0;
    chk("t3_addr5", LDM_ADDR, 5);
    LDM_FRAME_START = 1'b1;
    LDM_LINE_VALID  = 1'b1;
    LDM_LINE_DATA   = 16'hBEEF;
    tick();
    LDM_FRAME_START = 1'b0;
    LDM_LINE_VALID  = 1'b0;
    chk("t3_drop", FRAME_DROP, 1);
    chk("t3_addr1", LDM_ADDR, 1);
    tick();
    chk("t3_drop_pulse", FRAME_DROP, 0);
    for (int i = 1; i < 16; i++) send_line(16'hD000 + 16'(i));
    LDM_LINE_VALID = 1'b0;
    exp_f = mk_frame(16'hD000);
    exp_f[15:0] = 16'hBEEF;
    chk("t3_valid", PIXEL_DATA_VALID, 1);
    chk("t3_frame", PIXEL_DATA_256, exp_f);
    tick();

    // resync at line 0 is harmless
    chk("t4_addr0", LDM_ADDR, 0);
    LDM_FRAME_START = 1'b1;
    tick();
    LDM_FRAME_START = 1'b0;
    chk("t4_no_drop", FRAME_DROP, 0);
    chk("t4_addr", LDM_ADDR, 0);

    // resync while the final line is stalled
    PIXEL_DATA_READY = 1'b0;
    for (int i = 0; i < 16; i++) send_line(16'h6000 + 16'(i));
    for (int i = 0; i < 15; i++) send_line(16'h7000 + 16'(i));
    LDM_FRAME_START = 1'b1;
    LDM_LINE_VALID  = 1'b1;
    LDM_LINE_DATA   = 16'h700F;
    tick();
    LDM_FRAME_START = 1'b0;
    LDM_LINE_VALID  = 1'b0;
    chk("t5_drop", FRAME_DROP, 1);
    chk("t5_addr", LDM_ADDR, 0);
    chk("t5_held", PIXEL_DATA_256, mk_frame(16'h6000));
    PIXEL_DATA_READY = 1'b1;
    tick();
    chk("t5_drained", PIXEL_DATA_VALID, 0);

    // random handshakes, 1000 frames
    tx = 0;
    rx = 0;
    cyc = 0;
    while (rx < 1000 && cyc < 60000) begin
      d = {12'(tx / 16), 4'(tx % 16)};
      LDM_LINE_DATA    = d;
      LDM_LINE_VALID   = (tx < 16000) && ($urandom_range(3) != 0);
      PIXEL_DATA_READY = ($urandom_range(3) != 0);
      #1;
      acc = LDM_LINE_VALID && LDM_LINE_READY;
      if (PIXEL_DATA_VALID && PIXEL_DATA_READY) begin
        chk("rand_frame", PIXEL_DATA_256, pat_frame(rx));
        rx++;
      end
      @(posedge clk);
      #1;
      if (acc) tx++;
      cyc++;
    end
    LDM_LINE_VALID = 1'b0;
    chk("rand_frames_rx", 256'(rx), 256'(1000));
    chk("rand_lines_tx", 256'(tx), 256'(16000));

    // async reset mid-frame with a frame held
    PIXEL_DATA_READY = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) send_line(16'hE000 + 16'(i));
    for (int i = 0; i < 9; i++) send_line(16'hF000 + 16'(i));
    LDM_LINE_VALID = 1'b0;
    chk("t6_addr9", LDM_ADDR, 9);
    chk("t6_held", PIXEL_DATA_VALID, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", PIXEL_DATA_VALID, 0);
    chk("t6_rst_data", PIXEL_DATA_256, 0);
    chk("t6_rst_addr", LDM_ADDR, 0);
    chk("t6_rst_ready", LDM_LINE_READY, 1);
    tick();
    rstn = 1'b1;
    PIXEL_DATA_READY = 1'b1;
    for (int i = 0; i < 16; i++) send_line(16'h5A00 + 16'(i));
    LDM_LINE_VALID = 1'b0;
    chk("t6_clean_valid", PIXEL_DATA_VALID, 1);
    chk("t6_clean_frame", PIXEL_DATA_256, mk_frame(16'h5A00));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/s2p_line_packer.md
Name: s2p_line_packer

Overview:
- Inverse of the LDM frame-to-line unpacker.
- Collects 16 consecutive 16-bit LDM line words over a valid/ready stream and packs them into one 256-bit pixel frame.
- Presents the frame to downstream over a valid/ready handshake.
- Sits between the LDM line source and the pixel-frame consumer; double-buffered so the next frame can be collected while the previous one waits.

Parameters:
- LINE_W, 16, bits per line word.
- NUM_LINES, 16, line words per frame (power of two).
- DATA_W, LINE_W*NUM_LINES (256), frame width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- LDM_FRAME_START  in  1  resync strobe; the current or next accepted line is line 0.
- LDM_LINE_DATA  in  LINE_W  line word.
- LDM_LINE_VALID  in  1  LDM_LINE_DATA is valid.
- LDM_LINE_READY  out  1  packer accepts a line this cycle.
- LDM_ADDR  out  log2(NUM_LINES)  index the next accepted line is written to.
- PIXEL_DATA_256  out  DATA_W  assembled frame.
- PIXEL_DATA_VALID  out  1  PIXEL_DATA_256 holds an unconsumed frame.
- PIXEL_DATA_READY  in  1  downstream takes the frame.
- FRAME_DROP  out  1  one-cycle pulse: partial frame discarded by resync.

Behaviour:
- Reset (rstn low, async): line counter=0, assembly buffer=0, PIXEL_DATA_256=0, PIXEL_DATA_VALID=0, FRAME_DROP=0.
  - LDM_LINE_READY is 1 (combinational) and LDM_ADDR is 0.
  - Reset mid-frame discards all partial and held data.
- Line mapping: line k occupies PIXEL_DATA_256[LINE_W*k+LINE_W-1 : LINE_W*k]. Line 0 is least significant; line 15 is [255:240]. A packed frame fed back through the unpacker returns line k at LDM_ADDR=k.
- Accept: a line is taken on a rising edge with LDM_LINE_VALID && LDM_LINE_READY. It is written to the buffer slot at LDM_ADDR, then the counter increments.
- Counter: wraps NUM_LINES-1 -> 0 on the accept of the last line. LDM_ADDR = counter.
- Frame completion, on accept of line NUM_LINES-1:
  - The output register loads the assembly buffer merged with this final word, in the same edge.
  - PIXEL_DATA_VALID=1 after that edge, giving 1-cycle latency from last-line accept to valid frame.
  - The assembly buffer is not cleared; stale slots are overwritten by the next frame.
- States (implicit in PIXEL_DATA_VALID):
  - EMPTY (valid=0): lines always accepted.
  - HOLD (valid=1): lines 0..NUM_LINES-2 still accepted.
- Backpressure: LDM_LINE_READY = !(counter==NUM_LINES-1 && PIXEL_DATA_VALID && !PIXEL_DATA_READY). Only the final line stalls. It uses same-cycle PIXEL_DATA_READY, so there is no bubble when downstream drains in the same cycle.
- Output handshake: PIXEL_DATA_VALID && PIXEL_DATA_READY consumes the frame, and valid clears on the next edge. If a new frame completes on that same edge, valid stays 1 and PIXEL_DATA_256 takes the new frame. PIXEL_DATA_256 is stable while valid=1 and ready=0.
- Resync (LDM_FRAME_START=1 on an edge):
  - Counter forced to 0.
  - If a line is accepted on the same edge, it is written as line 0 and the counter becomes 1. This takes priority over the pre-existing counter value.
  - FRAME_DROP pulses for one cycle if the counter was nonzero before the edge. The partial frame is discarded; the output register is unaffected.
  - FRAME_START with counter==NUM_LINES-1 and ready low still resyncs. The stalled line is not accepted; FRAME_DROP pulses.
- LDM_LINE_DATA is ignored when not accepted. No X propagation: all registers are reset.

Decomposition:
- Shared package ldm_pkg holds:
  - LDM_LINE_W=16, LDM_NUM_LINES=16, LDM_ADDR_W=4, LDM_FRAME_W=256.
  - Line-slot helper function: slot k -> base bit LDM_LINE_W*k.
  - The unpacker uses the same package for mapping consistency.
- Single module, no sub-module. The counter and buffers are too small to warrant a split.

Test Plan:
- Reset then 16 back-to-back lines 16'h0000..16'h000F, PIXEL_DATA_READY=1 -> PIXEL_DATA_VALID high exactly 1 cycle after 16th accept; PIXEL_DATA_256[15:0]=0000, [255:240]=000F; valid drops the next cycle.
- Frame A complete, PIXEL_DATA_READY=0; stream frame B lines -> lines 0..14 accepted, LDM_LINE_READY=0 at LDM_ADDR=15; PIXEL_DATA_256 stays A. Raise ready -> line 15 accepted the same cycle; next cycle valid=1 with frame B.
- 5 lines accepted (LDM_ADDR=5), then LDM_FRAME_START with LDM_LINE_VALID=1 data 16'hBEEF -> FRAME_DROP one pulse; LDM_ADDR=1; completed frame has [15:0]=BEEF.
- LDM_FRAME_START at LDM_ADDR=0 -> no FRAME_DROP; counter unchanged.
- Random LDM_LINE_VALID/PIXEL_DATA_READY over 1000 frames with pattern {frame#,line#} -> every frame delivered in order with correct slots; no loss, no duplication.
- Assert rstn low mid-frame (LDM_ADDR=9) with valid frame held -> PIXEL_DATA_VALID=0, PIXEL_DATA_256=0, LDM_ADDR=0 immediately (async); next 16 lines form a clean frame.
